// File: rtl/img_binarize.sv
// RGB565 -> luma -> 1-bit threshold, 3-clk pipeline with hs/vs/de delayed to match.
// Threshold is manual or the previous frame's mean luma, divided out during blanking.
module img_binarize #(
  parameter logic [7:0] DEFAULT_TH = 8'd128,
  parameter bit         VS_POL     = 1'b1,
  parameter int         ACC_W      = 32,
  parameter int         CNT_W      = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        th_mode,
  input  logic [7:0]  th_manual,
  input  logic        in_hs,
  input  logic        in_vs,
  input  logic        in_de,
  input  logic [15:0] in_data,
  output logic        out_hs,
  output logic        out_vs,
  output logic        out_de,
  output logic        out_data,
  output logic [7:0]  cur_th,
  output logic        busy
);

  localparam int DC_W = $clog2(ACC_W + 1);

  typedef enum logic [1:0] {IDLE, DIV, LOAD} state_t;

  // Stage 1: channel expansion and weighted products
  logic [7:0]  r8, g8, b8;
  logic [15:0] pr_q, pg_q, pb_q;
  logic        hs1_q, vs1_q, de1_q;

  assign r8 = {in_data[15:11], in_data[15:13]};
  assign g8 = {in_data[10:5],  in_data[10:9]};
  assign b8 = {in_data[4:0],   in_data[4:2]};

  always_ff @(posedge clk) begin
    if (rst) begin
      pr_q  <= '0;
      pg_q  <= '0;
      pb_q  <= '0;
      hs1_q <= 1'b0;
      vs1_q <= 1'b0;
      de1_q <= 1'b0;
    end else begin
      pr_q  <= 16'(r8) * 16'd77;
      pg_q  <= 16'(g8) * 16'd150;
      pb_q  <= 16'(b8) * 16'd29;
      hs1_q <= in_hs;
      vs1_q <= in_vs;
      de1_q <= in_de;
    end
  end

  // Stage 2: luma; weights sum to 256 so the sum never exceeds 16 bits
  logic [7:0] y2_q;
  logic       hs2_q, vs2_q, de2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      y2_q  <= '0;
      hs2_q <= 1'b0;
      vs2_q <= 1'b0;
      de2_q <= 1'b0;
    end else begin
      y2_q  <= 8'((pr_q + pg_q + pb_q) >> 8);
      hs2_q <= hs1_q;
      vs2_q <= vs1_q;
      de2_q <= de1_q;
    end
  end

  // Stage 3: threshold and sync outputs
  logic       out_hs_q, out_vs_q, out_de_q, out_data_q;
  logic [7:0] cur_th_q, cur_th_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_hs_q   <= 1'b0;
      out_vs_q   <= 1'b0;
      out_de_q   <= 1'b0;
      out_data_q <= 1'b0;
    end else begin
      out_hs_q   <= hs2_q;
      out_vs_q   <= vs2_q;
      out_de_q   <= de2_q;
      out_data_q <= de2_q && (y2_q >= cur_th_q);
    end
  end

  // out_vs_q doubles as the extra vs2 delay for edge detection
  logic frame_edge;
  assign frame_edge = (vs2_q == VS_POL) && (out_vs_q != VS_POL);

  // Per-frame luma sum and pixel count, both saturating
  logic [ACC_W-1:0] sum_q, sum_sat;
  logic [ACC_W:0]   sum_inc;
  logic [CNT_W-1:0] cnt_q, cnt_sat;

  assign sum_inc = {1'b0, sum_q} + (ACC_W+1)'(y2_q);
  assign sum_sat = sum_inc[ACC_W] ? '1 : sum_inc[ACC_W-1:0];
  assign cnt_sat = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
      cnt_q <= '0;
    end else if (frame_edge) begin
      sum_q <= de2_q ? ACC_W'(y2_q) : '0;
      cnt_q <= de2_q ? CNT_W'(1)    : '0;
    end else if (de2_q) begin
      sum_q <= sum_sat;
      cnt_q <= cnt_sat;
    end
  end

  // Restoring divider: dividend shifts out of dq_q while quotient bits shift in
  state_t           state_q, state_d;
  logic [DC_W-1:0]  div_cnt_q, div_cnt_d;
  logic [ACC_W-1:0] dq_q, dq_d;
  logic [CNT_W-1:0] rem_q, rem_d, dvs_q, dvs_d;
  logic [CNT_W:0]   trial, diff;
  logic             qbit;

  assign trial = {rem_q, dq_q[ACC_W-1]};
  assign diff  = trial - {1'b0, dvs_q};
  assign qbit  = ~diff[CNT_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      div_cnt_q <= '0;
      dq_q      <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      cur_th_q  <= DEFAULT_TH;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      dq_q      <= dq_d;
      rem_q     <= rem_d;
      dvs_q     <= dvs_d;
      cur_th_q  <= cur_th_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    dq_d      = dq_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    cur_th_d  = cur_th_q;
    case (state_q)
      IDLE: begin
        if (frame_edge) begin
          if (!th_mode) begin
            cur_th_d = th_manual;
          end else if (cnt_q != '0) begin
            state_d   = DIV;
            dq_d      = sum_q;
            dvs_d     = cnt_q;
            rem_d     = '0;
            div_cnt_d = '0;
          end
        end
      end
      DIV: begin
        if (div_cnt_q == DC_W'(ACC_W)) begin
          state_d = LOAD;
        end else begin
          dq_d      = {dq_q[ACC_W-2:0], qbit};
          rem_d     = qbit ? diff[CNT_W-1:0] : trial[CNT_W-1:0];
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      LOAD: begin
        // mean of 8-bit samples always fits in 8 bits
        cur_th_d = dq_q[7:0];
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_hs   = out_hs_q;
  assign out_vs   = out_vs_q;
  assign out_de   = out_de_q;
  assign out_data = out_data_q;
  assign cur_th   = cur_th_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_img_binarize.sv
// Bench for img_binarize: frame-level reference model compared every cycle,
// plus directed literal expectations for luma values, thresholds and busy length.
module tb_img_binarize;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        th_mode = 1'b0;
  logic [7:0]  th_manual = 8'd128;
  logic        in_hs = 1'b0, in_vs = 1'b0, in_de = 1'b0;
  logic [15:0] in_data = 16'h0000;
  logic        out_hs, out_vs, out_de, out_data, busy;
  logic [7:0]  cur_th;

  int checks = 0;
  int failures = 0;
  int busy_cycles = 0;

  always #5 clk = ~clk;

  img_binarize dut (
    .clk(clk), .rst(rst), .th_mode(th_mode), .th_manual(th_manual),
    .in_hs(in_hs), .in_vs(in_vs), .in_de(in_de), .in_data(in_data),
    .out_hs(out_hs), .out_vs(out_vs), .out_de(out_de), .out_data(out_data),
    .cur_th(cur_th), .busy(busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int luma(input logic [15:0] d);
    int r, g, b, r8, g8, b8;
    r = int'(d >> 11) & 31;
    g = int'(d >> 5) & 63;
    b = int'(d) & 31;
    r8 = (r << 3) | (r >> 2);
    g8 = (g << 2) | (g >> 4);
    b8 = (b << 3) | (b >> 2);
    return (77 * r8 + 150 * g8 + 29 * b8) / 256;
  endfunction

  // Reference model: history of captured inputs plus frame statistics
  typedef struct {
    logic        hs, vs, de;
    logic [15:0] d;
  } smp_t;

  smp_t    hist[$];
  bit      chk_en = 1'b0;
  int      exp_th = 128;
  bit      exp_od = 1'b0;
  int      cd = 0;
  int      pend_q = 0;
  longint  m_sum = 0;
  longint  m_cnt = 0;

  always @(posedge clk) begin
    smp_t s2, s3, z, cur;
    int   y2, n;
    bit   idle, od_next;
    z = '{hs: 1'b0, vs: 1'b0, de: 1'b0, d: 16'h0};
    cur = '{hs: in_hs, vs: in_vs, de: in_de, d: in_data};
    if (rst) begin
      repeat (3) hist.push_back(z);
      exp_th = 128; cd = 0; m_sum = 0; m_cnt = 0; exp_od = 1'b0;
      chk_en = 1'b1;
    end else if (chk_en) begin
      n  = hist.size();
      s2 = hist[n-2];
      s3 = hist[n-3];
      y2 = luma(s2.d);
      od_next = s2.de && (y2 >= exp_th);
      idle = (cd == 0);
      if (cd > 0) begin
        cd--;
        if (cd == 0) exp_th = pend_q;
      end
      if (s2.vs && !s3.vs) begin
        if (idle) begin
          if (!th_mode) exp_th = int'(th_manual);
          else if (m_cnt != 0) begin
            cd = 34;
            pend_q = int'(m_sum / m_cnt);
          end
        end
        m_sum = 0;
        m_cnt = 0;
      end
      if (s2.de) begin
        m_sum += y2;
        m_cnt++;
      end
      exp_od = od_next;
      hist.push_back(cur);
    end
  end

  // Compare process: every cycle once reset has been seen
  always @(negedge clk) begin
    if (chk_en) begin
      smp_t s;
      s = hist[hist.size()-3];
      chk("out_hs", 32'(out_hs), 32'(s.hs));
      chk("out_vs", 32'(out_vs), 32'(s.vs));
      chk("out_de", 32'(out_de), 32'(s.de));
      chk("out_data", 32'(out_data), 32'(exp_od));
      chk("cur_th", 32'(cur_th), 32'(exp_th));
      chk("busy", 32'(busy), 32'(cd > 0));
      if (busy === 1'b1) busy_cycles++;
    end
  end

  task automatic drive(input logic hs, input logic vs, input logic de, input logic [15:0] d);
    in_hs = hs; in_vs = vs; in_de = de; in_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 16'h0);
  endtask

  task automatic vs_pulse();
    idle(3);
    drive(1'b0, 1'b1, 1'b0, 16'h0);
    drive(1'b0, 1'b1, 1'b0, 16'h0);
    idle(4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_de", 32'(out_de), 32'd0);
    chk("rst_out_vs", 32'(out_vs), 32'd0);
    chk("rst_cur_th", 32'(cur_th), 32'd128);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;

    // Manual 128 latched at first edge
    vs_pulse();
    chk("manual128_th", 32'(cur_th), 32'd128);

    // Extremes: white then black, out 3 clk later
    drive(1'b0, 1'b0, 1'b1, 16'hFFFF);
    drive(1'b0, 1'b0, 1'b1, 16'h0000);
    chk("ext_de_early", 32'(out_de), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 16'h0000);
    chk("ext_white_data", 32'(out_data), 32'd1);
    chk("ext_white_de", 32'(out_de), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 16'h0000);
    chk("ext_black_data", 32'(out_data), 32'd0);
    chk("ext_black_de", 32'(out_de), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 16'h0000);
    chk("ext_de_off", 32'(out_de), 32'd0);

    // Luma rounding: pure red gives Y = 76
    chk("luma_F800", 32'(luma(16'hF800)), 32'd76);
    th_manual = 8'd76;
    vs_pulse();
    chk("th76", 32'(cur_th), 32'd76);
    drive(1'b0, 1'b0, 1'b1, 16'hF800);
    idle(2);
    chk("red_at_76", 32'(out_data), 32'd1);
    th_manual = 8'd77;
    drive(1'b0, 1'b0, 1'b1, 16'hF800);
    idle(2);
    chk("red_mid_frame_th", 32'(out_data), 32'd1);
    vs_pulse();
    chk("th77", 32'(cur_th), 32'd77);
    drive(1'b0, 1'b0, 1'b1, 16'hF800);
    idle(2);
    chk("red_at_77", 32'(out_data), 32'd0);

    // Random sync patterns in manual mode
    for (int i = 0; i < 200; i++) begin
      if (i % 50 == 0) th_manual = 8'($urandom_range(0, 255));
      drive(1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom));
    end

    // Adaptive mean: 0,0,255,255 -> 127, busy 34 clk
    th_manual = 8'd128;
    idle(4);
    vs_pulse();
    th_mode = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 16'h0000);
    drive(1'b0, 1'b0, 1'b1, 16'h0000);
    drive(1'b0, 1'b0, 1'b1, 16'hFFFF);
    drive(1'b0, 1'b0, 1'b1, 16'hFFFF);
    busy_cycles = 0;
    vs_pulse();
    idle(40);
    chk("mean_busy_len", 32'(busy_cycles), 32'd34);
    chk("mean_th", 32'(cur_th), 32'd127);

    // Empty frame: no update, never busy
    busy_cycles = 0;
    vs_pulse();
    idle(40);
    chk("empty_busy", 32'(busy_cycles), 32'd0);
    chk("empty_th", 32'(cur_th), 32'd127);

    // Edge during DIV: first result loads, next frame starts from zero
    drive(1'b0, 1'b0, 1'b1, 16'hFFFF);
    drive(1'b0, 1'b0, 1'b1, 16'hFFFF);
    vs_pulse();
    chk("div_busy", 32'(busy), 32'd1);
    drive(1'b0, 1'b0, 1'b1, 16'hF800);
    vs_pulse();
    chk("div_busy2", 32'(busy), 32'd1);
    drive(1'b0, 1'b0, 1'b1, 16'h0000);
    drive(1'b0, 1'b0, 1'b1, 16'hFFFF);
    idle(40);
    chk("busy_edge_th", 32'(cur_th), 32'd255);
    vs_pulse();
    idle(40);
    chk("fresh_frame_th", 32'(cur_th), 32'd127);

    // Reset mid-division
    drive(1'b0, 1'b0, 1'b1, 16'hFFFF);
    vs_pulse();
    idle(6);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    idle(1);
    chk("rst_div_busy", 32'(busy), 32'd0);
    chk("rst_div_th", 32'(cur_th), 32'd128);
    rst = 1'b0;
    idle(8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
